sensor_stream_packer: RTL and testbench

//  Return path of the MSTREAM pattern interface: captures 20-bit sensor readout samples on clk,

---
 rtl/sensor_stream_packer_if.sv | 33 +++
 rtl/sensor_stream_packer.sv | 136 +++++++++++++
 tb/tb_sensor_stream_packer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sensor_stream_packer_if.sv
// Bundle of control, sensor and readout-FIFO signals for the packer.
// Ports: start/num_samples/sensor_*/fifo_almost_full in; fifo_din/wr_en/status out.
interface sensor_stream_packer_if #(
  parameter int SENSOR_W = 20,
  parameter int LANE_W   = 32,
  parameter int LANES    = 8
);
  logic                      start;
  logic [31:0]               num_samples;
  logic [SENSOR_W-1:0]       sensor_data;
  logic                      sensor_valid;
  logic [LANE_W*LANES-1:0]   fifo_din;
  logic                      fifo_wr_en;
  logic                      fifo_almost_full;
  logic                      busy;
  logic                      done;
  logic                      overflow;
  logic [31:0]               sample_count;

  modport master (
    output start, num_samples, sensor_data, sensor_valid,
    output fifo_almost_full,
    input  fifo_din, fifo_wr_en, busy, done, overflow,
    input  sample_count
  );

  modport slave (
    input  start, num_samples, sensor_data, sensor_valid,
    input  fifo_almost_full,
    output fifo_din, fifo_wr_en, busy, done, overflow,
    output sample_count
  );
endinterface

// File: rtl/sensor_stream_packer.sv
// Packs zero-extended 20-bit sensor samples into 256-bit readout FIFO words.
// Ports: clk, reset (async, active-low), bus (slave modport).
// Macro SENSOR_PACK_SEQNUM_EN: lane 7 holds a per-run word sequence number.
module sensor_stream_packer #(
  parameter int SENSOR_W = 20,
  parameter int LANE_W   = 32,
  parameter int LANES    = 8
) (
  input logic clk,
  input logic reset,
  sensor_stream_packer_if.slave bus
);

  localparam int OUT_W = LANE_W * LANES;
  localparam int IW    = $clog2(LANES);
`ifdef SENSOR_PACK_SEQNUM_EN
  localparam int DLANES = LANES - 1;
`else
  localparam int DLANES = LANES;
`endif
  localparam logic [IW-1:0] LAST = IW'(DLANES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]          state;
  logic [IW-1:0]       idx;
  logic [31:0]         num_q;
  logic [31:0]         cnt;
  logic                ovf;
  logic [OUT_W-1:0]    wbuf;
  logic [OUT_W-1:0]    din;
  logic                wr;
`ifdef SENSOR_PACK_SEQNUM_EN
  logic [LANE_W-1:0]   seq;
`endif

  logic [SENSOR_W-1:0] sample;
  logic [OUT_W-1:0]    merged;
  logic [OUT_W-1:0]    pack_word;
  logic                start_ok;
  logic                take;
  logic                last;
  logic                wfull;
  logic                emit;

  assign sample   = bus.sensor_data;
  assign start_ok = bus.start &&
                    (state == IDLE || state == DONE);
  assign take     = (state == CAPTURE) && bus.sensor_valid;
  assign last     = take && (cnt == num_q - 32'd1);
  assign wfull    = take && (idx == LAST);
  // A word leaves either when its last lane fills or on flush.
  assign emit     = wfull || (state == FLUSH);

  always_comb begin
    merged = wbuf;
    merged[idx*LANE_W +: LANE_W] = LANE_W'(sample);
  end

  // Flush sends the partial buffer; unfilled lanes are already zero.
  always_comb begin
    pack_word = (state == FLUSH) ? wbuf : merged;
`ifdef SENSOR_PACK_SEQNUM_EN
    pack_word[OUT_W-1 -: LANE_W] = seq;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      num_q <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      wbuf  <= '0;
      din   <= '0;
      wr    <= 1'b0;
`ifdef SENSOR_PACK_SEQNUM_EN
      seq   <= '0;
`endif
    end else begin
      wr <= 1'b0;
      if (start_ok) begin
        num_q <= bus.num_samples;
        cnt   <= '0;
        ovf   <= 1'b0;
        idx   <= '0;
        wbuf  <= '0;
`ifdef SENSOR_PACK_SEQNUM_EN
        seq   <= '0;
`endif
        state <= (bus.num_samples == 32'd0) ? DONE : CAPTURE;
      end else begin
        if (take) begin
          if (cnt != '1)
            cnt <= cnt + 32'd1;
          if (wfull) begin
            idx  <= '0;
            wbuf <= '0;
          end else begin
            idx  <= idx + 1'b1;
            wbuf <= merged;
          end
          if (last)
            state <= wfull ? DONE : FLUSH;
        end
        if (state == FLUSH)
          state <= DONE;
        if (emit) begin
          // A nearly full FIFO costs the word, not the run.
          if (bus.fifo_almost_full) begin
            ovf <= 1'b1;
          end else begin
            wr  <= 1'b1;
            din <= pack_word;
          end
`ifdef SENSOR_PACK_SEQNUM_EN
          seq <= seq + 1'b1;
`endif
        end
      end
    end
  end

  assign bus.fifo_din     = din;
  assign bus.fifo_wr_en   = wr;
  assign bus.busy         = (state == CAPTURE) ||
                            (state == FLUSH);
  assign bus.done         = (state == DONE);
  assign bus.overflow     = ovf;
  assign bus.sample_count = cnt;

endmodule

// File: tb/tb_sensor_stream_packer.sv
// Randomized and directed bench for sensor_stream_packer.
// Reference model packs sample lists into expected words with plain arithmetic.
module tb_sensor_stream_packer;

`ifdef SENSOR_PACK_SEQNUM_EN
  localparam int LPW = 7;
  localparam logic [255:0] T1W = {
    32'h0, 32'h7, 32'h6, 32'h5,
    32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [255:0] T2W = {
    32'h0, 128'b0,
    32'hC, 32'hB, 32'hA};
`else
  localparam int LPW = 8;
  localparam logic [255:0] T1W = {
    32'h8, 32'h7, 32'h6, 32'h5,
    32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [255:0] T2W = {
    160'b0, 32'hC, 32'hB, 32'hA};
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sensor_stream_packer_if bus ();

  sensor_stream_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [255:0] got[$];

  always @(negedge clk)
    if (bus.fifo_wr_en === 1'b1)
      got.push_back(bus.fifo_din);

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // afmode: 0 never full, 1 random, 2 full at first word only.
  // base < 0 gives random data, else base, base+1, ...
  task automatic run(input string tag, input int n,
                     input int vpct, input int afmode,
                     input int base);
    logic [31:0] smp[$];
    bit afq[$];
    logic [255:0] exp[$];
    logic [255:0] w;
    bit eovf;
    bit v;
    bit af;
    int cyc;
    int li;
    eovf = 1'b0;
    got.delete();
    bus.start = 1'b1;
    bus.num_samples = n;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (smp.size() < n && cyc < 100 * n + 20) begin
      cyc++;
      v = ($urandom_range(99) < vpct);
      af = 1'b0;
      if (afmode == 1)
        af = $urandom_range(1);
      if (afmode == 2)
        af = (smp.size() == LPW - 1);
      bus.sensor_valid = v;
      if (base < 0)
        bus.sensor_data = 20'($urandom);
      else
        bus.sensor_data = 20'(base + smp.size());
      bus.fifo_almost_full = af;
      // Restarts mid-run must be ignored.
      bus.start = ($urandom_range(15) == 0);
      bus.num_samples = $urandom;
      if (v) begin
        smp.push_back(32'(bus.sensor_data));
        afq.push_back(af);
      end
      @(posedge clk); #1;
      chk({tag, "_wr_lat"}, bus.fifo_wr_en,
          v && (smp.size() % LPW == 0) && !af);
    end
    bus.start = 1'b0;
    bus.sensor_valid = 1'b0;
    bus.fifo_almost_full = 1'b0;
    chk({tag, "_fed"}, smp.size(), n);
    for (int c = 0; c < 8 && bus.done !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, bus.done, 1'b1);
    @(negedge clk); #1;
    for (int k = 0; k * LPW < n; k++) begin
      w = '0;
      for (int j = 0; j < LPW; j++)
        if (k * LPW + j < n)
          w[j*32 +: 32] = smp[k*LPW + j];
      if (LPW == 7)
        w[255:224] = 32'(k);
      li = k * LPW + LPW - 1;
      if (li < n && afq[li])
        eovf = 1'b1;
      else
        exp.push_back(w);
    end
    chk({tag, "_nwords"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), got[i], exp[i]);
    chk({tag, "_count"}, bus.sample_count, n);
    chk({tag, "_ovf"}, bus.overflow, eovf);
    chk({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.num_samples = '0;
    bus.sensor_data = '0;
    bus.sensor_valid = 1'b0;
    bus.fifo_almost_full = 1'b0;
    #1 reset = 1'b0;
    #20;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_count", bus.sample_count, 32'd0);
    chk("rst_din", bus.fifo_din, 256'd0);
    chk("rst_wr", bus.fifo_wr_en, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run("t1", 8, 100, 0, 1);
    chk("t1_const", got[0], T1W);

    run("t2", 3, 100, 0, 'hA);
    chk("t2_const", got[0], T2W);

    run("t3", 16, 100, 2, 1);

    run("t4", 0, 100, 0, -1);
    chk("t4_nowr", got.size(), 0);

    // Reset in the middle of a run.
    got.delete();
    bus.start = 1'b1;
    bus.num_samples = 8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sensor_valid = 1'b1;
      bus.sensor_data = 20'(i + 1);
      @(posedge clk); #1;
    end
    bus.sensor_valid = 1'b0;
    reset = 1'b0;
    #2;
    chk("t5_count", bus.sample_count, 32'd0);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_done", bus.done, 1'b0);
    chk("t5_din", bus.fifo_din, 256'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_nowr", got.size(), 0);
    run("t5b", 8, 100, 0, 1);
    chk("t5b_const", got[0], T1W);

    run("t6", 14, 60, 0, -1);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 40);
      run($sformatf("rnd%0d", r), n,
          $urandom_range(40, 100), 0, -1);
    end
    for (int r = 0; r < 4; r++) begin
      n = LPW * $urandom_range(1, 5);
      run($sformatf("ovf%0d", r), n,
          $urandom_range(50, 100), 1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
